// File: rtl/fft_twiddle_sequencer.sv
// Address and twiddle-index sequencer for an in-place radix-2 DIT FFT.
// Issues log2(N) stages of N/2 butterfly descriptors, one per bf_val/bf_rdy handshake.
module fft_twiddle_sequencer #(
  parameter int unsigned N         = 8,
  parameter int unsigned STAGE_GAP = 2,
  localparam int unsigned LG       = $clog2(N),
  localparam int unsigned SW       = (LG > 1) ? $clog2(LG) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_val,
  output logic          start_rdy,
  output logic          bf_val,
  input  logic          bf_rdy,
  output logic [LG-1:0] bf_addr_a,
  output logic [LG-1:0] bf_addr_b,
  output logic [LG-1:0] bf_sin_idx,
  output logic [LG-1:0] bf_cos_idx,
  output logic [SW-1:0] bf_stage,
  output logic          bf_last,
  output logic          done
);

  localparam int unsigned GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP + 1) : 1;
  localparam logic [LG-1:0] LAST_B  = LG'(N / 2 - 1);
  localparam logic [SW-1:0] LAST_S  = SW'(LG - 1);
  localparam logic [LG-1:0] QUARTER = LG'(N / 4);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [LG-1:0] bfly_q,  bfly_d;
  logic [GW-1:0] gap_q,   gap_d;

  logic [LG-1:0] half, mask, j, addr_a, k;

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      bfly_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state and counter advance; counters only move on a handshake or in GAP
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (start_val) begin
          state_d = RUN;
          stage_d = '0;
          bfly_d  = '0;
        end
      end
      RUN: begin
        if (bf_rdy) begin
          if (bfly_q != LAST_B) begin
            bfly_d = bfly_q + LG'(1);
          end else if (stage_q != LAST_S) begin
            bfly_d  = '0;
            stage_d = stage_q + SW'(1);
            if (STAGE_GAP > 0) begin
              state_d = GAP;
              gap_d   = GW'(STAGE_GAP);
            end
          end else begin
            state_d = DONE;
          end
        end
      end
      GAP: begin
        if (gap_q <= GW'(1)) state_d = RUN;
        else                 gap_d   = gap_q - GW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Descriptor math from (stage, butterfly): a = 2*g*half + j, k = j << (LG-1-s)
  always_comb begin
    half   = LG'(1) << stage_q;
    mask   = half - LG'(1);
    j      = bfly_q & mask;
    addr_a = ((bfly_q & ~mask) << 1) | j;
    k      = j << (LG'(LG - 1) - LG'(stage_q));
  end

  // Output decode from registered state only; everything forced low during reset
  always_comb begin
    start_rdy  = 1'b0;
    bf_val     = 1'b0;
    done       = 1'b0;
    bf_addr_a  = '0;
    bf_addr_b  = '0;
    bf_sin_idx = '0;
    bf_cos_idx = '0;
    bf_stage   = '0;
    bf_last    = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: start_rdy = 1'b1;
        RUN: begin
          bf_val     = 1'b1;
          bf_addr_a  = addr_a;
          bf_addr_b  = addr_a + half;
          bf_sin_idx = k;
          bf_cos_idx = k + QUARTER;
          bf_stage   = stage_q;
          bf_last    = (stage_q == LAST_S) && (bfly_q == LAST_B);
        end
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench: three sequencer instances (N=8 gap 0, N=8 gap 2, N=16 gap 0).
module tb_fft_twiddle_sequencer;

  logic clk, reset;

  // N=8, STAGE_GAP=0
  logic       sv0, sr0, bv0, br0, last0, done0;
  logic [2:0] a0, b0, si0, ci0;
  logic [1:0] st0;
  // N=8, STAGE_GAP=2
  logic       sv2, sr2, bv2, br2, last2, done2;
  logic [2:0] a2, b2, si2, ci2;
  logic [1:0] st2;
  // N=16, STAGE_GAP=0
  logic       sv16, sr16, bv16, br16, last16, done16;
  logic [3:0] a16, b16, si16, ci16;
  logic [1:0] st16;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt0 = 0, done_cnt2 = 0, done_cnt16 = 0;

  // Expected N=8 schedule, hand-derived
  int exp_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_k [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int exp_c [12] = '{2, 2, 2, 2, 2, 4, 2, 4, 2, 3, 4, 5};
  // bf_val per cycle for the gap-2 run, first bf_val cycle at index 0
  int exp_gv [16] = '{1,1,1,1, 0,0, 1,1,1,1, 0,0, 1,1,1,1};

  fft_twiddle_sequencer #(.N(8), .STAGE_GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .start_val(sv0), .start_rdy(sr0), .bf_val(bv0), .bf_rdy(br0),
    .bf_addr_a(a0), .bf_addr_b(b0), .bf_sin_idx(si0), .bf_cos_idx(ci0), .bf_stage(st0),
    .bf_last(last0), .done(done0));

  fft_twiddle_sequencer #(.N(8), .STAGE_GAP(2)) u_g2 (
    .clk(clk), .reset(reset), .start_val(sv2), .start_rdy(sr2), .bf_val(bv2), .bf_rdy(br2),
    .bf_addr_a(a2), .bf_addr_b(b2), .bf_sin_idx(si2), .bf_cos_idx(ci2), .bf_stage(st2),
    .bf_last(last2), .done(done2));

  fft_twiddle_sequencer #(.N(16), .STAGE_GAP(0)) u_n16 (
    .clk(clk), .reset(reset), .start_val(sv16), .start_rdy(sr16), .bf_val(bv16), .bf_rdy(br16),
    .bf_addr_a(a16), .bf_addr_b(b16), .bf_sin_idx(si16), .bf_cos_idx(ci16), .bf_stage(st16),
    .bf_last(last16), .done(done16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses per instance
  always @(posedge clk) begin
    if (done0)  done_cnt0  <= done_cnt0 + 1;
    if (done2)  done_cnt2  <= done_cnt2 + 1;
    if (done16) done_cnt16 <= done_cnt16 + 1;
  end

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int pk(input int s, input int a, input int b, input int k, input int c, input int l);
    return (s << 13) | (a << 10) | (b << 7) | (k << 4) | (c << 1) | l;
  endfunction

  function automatic int exp_pk(input int i);
    return pk(i / 4, exp_a[i], exp_b[i], exp_k[i], exp_c[i], (i == 11) ? 1 : 0);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc, held, cur;
    logic [15:0] rdy_pat;
    reset = 1'b1;
    sv0 = 0; br0 = 0; sv2 = 0; br2 = 0; sv16 = 0; br16 = 0;

    // Reset: every output low while reset is high
    repeat (3) tick();
    check("rst start_rdy", sr0, 0);
    check("rst bf_val", bv0, 0);
    check("rst done", done0, 0);
    check("rst addr_a", a0, 0);
    check("rst addr_b", b0, 0);
    check("rst sin", si0, 0);
    check("rst cos", ci0, 0);
    check("rst stage", st0, 0);
    check("rst last", last0, 0);
    check("rst start_rdy n16", sr16, 0);
    reset = 1'b0;
    tick();
    check("post-rst start_rdy", sr0, 1);
    check("post-rst bf_val", bv0, 0);
    check("post-rst done", done0, 0);

    // Full N=8 schedule with bf_rdy=1; start_val held high through RUN and DONE
    br0 = 1'b1;
    sv0 = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      check($sformatf("g0 d%0d val", i), bv0, 1);
      check($sformatf("g0 d%0d stage", i), st0, i / 4);
      check($sformatf("g0 d%0d a", i), a0, exp_a[i]);
      check($sformatf("g0 d%0d b", i), b0, exp_b[i]);
      check($sformatf("g0 d%0d sin", i), si0, exp_k[i]);
      check($sformatf("g0 d%0d cos", i), ci0, exp_c[i]);
      check($sformatf("g0 d%0d last", i), last0, (i == 11) ? 1 : 0);
      check($sformatf("g0 d%0d done", i), done0, 0);
      tick();
    end
    check("g0 done pulse", done0, 1);
    check("g0 done bf_val", bv0, 0);
    check("g0 done start_rdy", sr0, 0);
    tick();
    check("g0 idle start_rdy", sr0, 1);
    check("g0 idle done", done0, 0);
    check("g0 done count 1", done_cnt0, 1);
    // start_val still high here: back-to-back start taken at the IDLE cycle
    tick();
    sv0 = 1'b0;
    check("g0 b2b val", bv0, 1);
    check("g0 b2b first", pk(st0, a0, b0, si0, ci0, last0), exp_pk(0));

    // Backpressure on the second transform
    rdy_pat = 16'b1011_0110_1001_0110;
    idx = 0; cyc = 0; held = -1;
    while (idx < 12 && cyc < 200) begin
      cur = pk(st0, a0, b0, si0, ci0, last0);
      if (held >= 0) check($sformatf("bp hold c%0d", cyc), cur, held);
      check($sformatf("bp val c%0d", cyc), bv0, 1);
      br0 = rdy_pat[cyc % 16];
      if (bv0 && br0) begin
        check($sformatf("bp acc %0d", idx), cur, exp_pk(idx));
        idx++;
        held = -1;
      end else if (bv0) begin
        held = cur;
      end else begin
        held = -1;
      end
      tick();
      cyc++;
    end
    check("bp accepted count", idx, 12);
    check("bp done pulse", done0, 1);
    br0 = 1'b1;
    tick();
    check("bp idle start_rdy", sr0, 1);
    check("g0 done count 2", done_cnt0, 2);

    // Stage gap: N=8, STAGE_GAP=2, start_val pulsed again during the gap
    br2 = 1'b1;
    sv2 = 1'b1;
    tick();
    sv2 = 1'b0;
    idx = 0;
    for (int i = 0; i < 17; i++) begin
      sv2 = (i == 4 || i == 5);
      check($sformatf("gap c%0d done", i), done2, (i == 16) ? 1 : 0);
      if (i < 16) begin
        check($sformatf("gap c%0d val", i), bv2, exp_gv[i]);
        if (bv2 && idx < 12) begin
          check($sformatf("gap d%0d", idx), pk(st2, a2, b2, si2, ci2, last2), exp_pk(idx));
          idx++;
        end
      end
      tick();
    end
    sv2 = 1'b0;
    check("gap desc count", idx, 12);
    check("gap start_rdy", sr2, 1);
    check("gap done count", done_cnt2, 1);

    // Reset during stage 1 of an N=16 transform
    br16 = 1'b1;
    sv16 = 1'b1;
    tick();
    sv16 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        check("n16 s1b1 stage", st16, 1);
        check("n16 s1b1 a", a16, 1);
        check("n16 s1b1 b", b16, 3);
        check("n16 s1b1 sin", si16, 4);
        check("n16 s1b1 cos", ci16, 8);
      end
      if (i < 9) tick();
    end
    reset = 1'b1;
    tick();
    check("n16 in-rst val", bv16, 0);
    check("n16 in-rst start_rdy", sr16, 0);
    check("n16 in-rst done", done16, 0);
    reset = 1'b0;
    tick();
    check("n16 post-rst start_rdy", sr16, 1);
    check("n16 post-rst val", bv16, 0);
    check("n16 post-rst done", done16, 0);
    sv16 = 1'b1;
    tick();
    sv16 = 1'b0;
    br16 = 1'b0;
    check("n16 restart val", bv16, 1);
    check("n16 restart stage", st16, 0);
    check("n16 restart a", a16, 0);
    check("n16 restart b", b16, 1);
    check("n16 restart sin", si16, 0);
    check("n16 restart cos", ci16, 4);
    repeat (3) tick();
    check("n16 stall hold a", a16, 0);
    check("n16 no done", done_cnt16, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_sequencer.md
# fft_twiddle_sequencer

Address and twiddle-index sequencer for the iterative, in-place radix-2 DIT FFT. On each accepted start it issues the full butterfly schedule: log2(N) stages of N/2 butterflies each, one per handshake. Each butterfly carries its two data-memory addresses and the sine-table and cosine-table indices of its twiddle factor. Those indices address the N-entry sine table (entry i = sin(2πi/N)); cos(2πk/N) is read as sine entry (k + N/4) mod N. Input bit-reversal/loading and the butterfly arithmetic live outside this block.

## Interface
- N, 8: FFT size; power of two, ≥ 4
- STAGE_GAP, 2: idle cycles inserted between stages so the butterfly pipeline drains; 0 allowed
- LG (derived), $clog2(N): address/index width
- SW (derived), max(1, $clog2(LG)): stage-number width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start_val  in  1  request a new transform
- start_rdy  out  1  block idle and able to accept start
- bf_val  out  1  butterfly descriptor valid
- bf_rdy  in  1  consumer accepts descriptor
- bf_addr_a  out  LG  top (even) operand address
- bf_addr_b  out  LG  bottom operand address (= addr_a + 2^stage)
- bf_sin_idx  out  LG  twiddle index k
- bf_cos_idx  out  LG  (k + N/4) mod N
- bf_stage  out  SW  current stage s
- bf_last  out  1  descriptor is the final butterfly of the transform
- done  out  1  one-cycle pulse after the last butterfly is accepted

## Operation
- States: IDLE, RUN, GAP, DONE.
- Reset: state=IDLE, stage=0, bfly=0, gap counter=0. All outputs 0 while reset is high, including start_rdy.
- IDLE: start_rdy=1. start_val && start_rdy → RUN, stage=0, bfly=0.
- RUN: bf_val=1; descriptors are a function of (stage s, bfly b) only.
  - half = 2^s; j = b mod half; g = b / half
  - addr_a = 2·g·half + j; addr_b = addr_a + half
  - k = j << (LG−1−s); cos_idx = (k + N/4) mod N, LG-bit wrap
  - bf_last = (s == LG−1) && (b == N/2−1)
- Advance only on bf_val && bf_rdy:
  - If b < N/2−1: b++.
  - Else if s < LG−1: b=0, s++, then GAP if STAGE_GAP>0 (counter loaded to STAGE_GAP), else stay in RUN.
  - Else: go to DONE.
- bf_rdy low: all descriptor outputs hold stable; no counter moves.
- GAP: bf_val=0; counter decrements each cycle; on reaching 1 → RUN. Exactly STAGE_GAP cycles with bf_val=0. No gap after the final stage.
- DONE: bf_val=0, start_rdy=0, done=1 for exactly one cycle → IDLE.
- start_val outside IDLE is ignored; it is not queued.
- Reset asserted in any state aborts the transform. The next cycle after deassertion is IDLE with counters zeroed; no done pulse is produced.

## Timing
- Start accepted at edge t → bf_val=1 in cycle t+1 with (s=0, b=0).
- With bf_rdy held high: one descriptor per cycle. Total transform = (N/2)·LG descriptors + (LG−1)·STAGE_GAP gap cycles.
- done asserts the cycle after the bf_last handshake. start_rdy reasserts the cycle after done.
- All outputs are registered or decoded from registered state only. No combinational path from bf_rdy or start_val to any output.

## Test plan
- Reset values: hold reset 3 cycles → every output 0. After deassertion, start_rdy=1, bf_val=0, done=0.
- Full schedule, N=8, STAGE_GAP=0, bf_rdy=1:
  - 12 consecutive descriptors.
  - Stage 0 (a,b,k): (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3); cos_idx = 2,3,4,5; bf_last only on the final one.
  - done one cycle later; start_rdy the cycle after that.
- Stage gap, N=8, STAGE_GAP=2 → exactly 2 bf_val=0 cycles after the 4th and after the 8th handshake. Total 16 cycles from first bf_val to done.
- Backpressure: random bf_rdy → descriptors stable while bf_rdy=0. Accepted sequence identical to the bf_rdy=1 run.
- Reset mid-run: assert reset during stage 1 of an N=16 transform → no done. Next start yields (s=0, b=0, a=0, b_addr=1, k=0, cos=4).
- Start while busy: pulse start_val during RUN and during DONE → ignored; exactly one done per accepted start. Back-to-back starts succeed at the IDLE cycle.
